niosdramproc_hcecho: RTL and testbench



---
 rtl/niosdramproc_hcecho_pkg.sv | 35 +++
 rtl/niosdramproc_hcecho_sync.sv | 54 +++++
 rtl/niosdramproc_hcecho.sv | 126 ++++++++++++
 tb/tb_niosdramproc_hcecho.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/niosdramproc_hcecho_pkg.sv
// Shared definitions for the HC-SR04 echo timer: register map, bit indices, FSM states.
package niosdramproc_hcecho_pkg;

  localparam logic [1:0] ADDR_WIDTH   = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

  localparam int unsigned ST_DONE = 0;
  localparam int unsigned ST_TMO  = 1;
  localparam int unsigned ST_BUSY = 2;
  localparam int unsigned ST_ECHO = 3;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_LOW,
    S_WAIT_RISE,
    S_MEASURE
  } state_t;

  function automatic logic [31:0] pack_status(input logic done, input logic tmo,
                                              input logic busy, input logic echo);
    logic [31:0] s;
    s          = '0;
    s[ST_DONE] = done;
    s[ST_TMO]  = tmo;
    s[ST_BUSY] = busy;
    s[ST_ECHO] = echo;
    return s;
  endfunction

endpackage

// File: rtl/niosdramproc_hcecho_sync.sv
// Two-flop synchronizer for the echo pin, followed by an optional glitch filter
// (enabled by defining HCECHO_GLITCH_FILTER_EN).
module niosdramproc_hcecho_sync #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic echo_in,
  output logic echo_s,
  output logic echo_f
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      echo_s <= 1'b0;
    end else begin
      meta   <= echo_in;
      echo_s <= meta;
    end
  end

`ifdef HCECHO_GLITCH_FILTER_EN
  localparam int unsigned FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [FC_W-1:0] stable_cnt;

  // echo_f follows echo_s only once the new level has held FILT_LEN cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_f     <= 1'b0;
      stable_cnt <= '0;
    end else if (echo_s == echo_f) begin
      stable_cnt <= '0;
    end else if (stable_cnt == FC_W'(FILT_LEN - 1)) begin
      echo_f     <= echo_s;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end
`else
  assign echo_f = echo_s;
`endif

  generate
    if (FILT_LEN == 0) begin : g_bad_filt_len
      $error("FILT_LEN must be at least 1");
    end
  endgenerate

endmodule

// File: rtl/niosdramproc_hcecho.sv
// Avalon-MM echo pulse timer for the HC-SR04 ranger with timeout and sticky status.
// Optional glitch filter on the echo input: define HCECHO_GLITCH_FILTER_EN.
module niosdramproc_hcecho
  import niosdramproc_hcecho_pkg::*;
#(
  parameter int unsigned CNT_W       = 24,
  parameter logic [31:0] TIMEOUT_DEF = 32'd1900000,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        echo_in,
  output logic        irq
);

  logic             echo_s_unused;
  logic             echo_f;
  logic             wr;
  logic             en;
  logic             irq_en;
  logic [CNT_W-1:0] timeout_r;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] width_r;
  logic             done;
  logic             tmo;
  state_t           state;
  logic             unused_wdata;

  niosdramproc_hcecho_sync #(
    .FILT_LEN(FILT_LEN)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .echo_in(echo_in),
    .echo_s (echo_s_unused),
    .echo_f (echo_f)
  );

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en        <= 1'b0;
      irq_en    <= 1'b0;
      timeout_r <= TIMEOUT_DEF[CNT_W-1:0];
      irq       <= 1'b0;
    end else begin
      if (wr && address == ADDR_CONTROL) begin
        en     <= writedata[CTRL_EN];
        irq_en <= writedata[CTRL_IRQ_EN];
      end
      if (wr && address == ADDR_TIMEOUT) begin
        timeout_r <= writedata[CNT_W-1:0];
      end
      irq <= irq_en & (done | tmo);
    end
  end

  // W1C is applied first so a same-cycle hardware set overrides the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      width_r <= '0;
      done    <= 1'b0;
      tmo     <= 1'b0;
    end else begin
      if (wr && address == ADDR_STATUS) begin
        if (writedata[ST_DONE]) done <= 1'b0;
        if (writedata[ST_TMO])  tmo  <= 1'b0;
      end
      if (!en) begin
        state <= S_IDLE;
        count <= '0;
      end else begin
        case (state)
          S_IDLE: state <= S_WAIT_LOW;
          S_WAIT_LOW: begin
            if (!echo_f) state <= S_WAIT_RISE;
          end
          S_WAIT_RISE: begin
            if (echo_f) begin
              count <= CNT_W'(1);
              state <= S_MEASURE;
            end
          end
          S_MEASURE: begin
            if (!echo_f) begin
              width_r <= count;
              done    <= 1'b1;
              state   <= S_WAIT_RISE;
            end else if (timeout_r != '0 && count == timeout_r) begin
              width_r <= timeout_r;
              tmo     <= 1'b1;
              state   <= S_WAIT_LOW;
            end else if (count != '1) begin
              count <= count + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_WIDTH:   readdata = 32'(width_r);
      ADDR_STATUS:  readdata = pack_status(done, tmo, state == S_MEASURE, echo_f);
      ADDR_CONTROL: begin
        readdata[CTRL_EN]     = en;
        readdata[CTRL_IRQ_EN] = irq_en;
      end
      ADDR_TIMEOUT: readdata = 32'(timeout_r);
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_niosdramproc_hcecho.sv
// Directed self-checking bench for the HC-SR04 echo timer.
module tb_niosdramproc_hcecho;

`ifdef HCECHO_GLITCH_FILTER_EN
  localparam int unsigned LAT = 6;
`else
  localparam int unsigned LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        echo_in = 1'b0;
  logic        irq;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  niosdramproc_hcecho #(
    .CNT_W(24),
    .TIMEOUT_DEF(32'd1900000),
    .FILT_LEN(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .echo_in   (echo_in),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic pulse(input int unsigned n);
    @(posedge clk);
    #1;
    echo_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    echo_in = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    cyc(3);
    rd(2'd0, v); n_cmp++;
    if (v !== 32'd0) begin n_err++; $display("FAIL reset_width got %0h want 0", v); end
    rd(2'd1, v); n_cmp++;
    if (v !== 32'd0) begin n_err++; $display("FAIL reset_status got %0h want 0", v); end
    rd(2'd2, v); n_cmp++;
    if (v !== 32'd0) begin n_err++; $display("FAIL reset_control got %0h want 0", v); end
    rd(2'd3, v); n_cmp++;
    if (v !== 32'd1900000) begin n_err++; $display("FAIL reset_timeout got %0d want 1900000", v); end
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_basic;
    logic [31:0] v;
    wr(2'd2, 32'h3);
    cyc(3);
    @(posedge clk); #1; echo_in = 1'b1;
    cyc(10);
    rd(2'd1, v); n_cmp++;
    if (v !== 32'hC) begin n_err++; $display("FAIL basic_busy status got %0h want c", v); end
    cyc(90);
    echo_in = 1'b0;
    cyc(LAT + 3);
    rd(2'd0, v); n_cmp++;
    if (v !== 32'd100) begin n_err++; $display("FAIL basic_width got %0d want 100", v); end
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h1) begin n_err++; $display("FAIL basic_status got %0h want 1", v); end
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL basic_irq got %b want 1", irq); end
    wr(2'd1, 32'h1);
    cyc(2);
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL basic_w1c status got %0h want 0", v); end
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL basic_w1c_irq got %b want 0", irq); end
  endtask

  task automatic test_partial;
    logic [31:0] v;
    wr(2'd2, 32'h0);
    cyc(3);
    echo_in = 1'b1;
    cyc(5);
    wr(2'd2, 32'h3);
    cyc(30);
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h8) begin n_err++; $display("FAIL partial_wait_low status got %0h want 8", v); end
    echo_in = 1'b0;
    cyc(LAT + 3);
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL partial_no_done status got %0h want 0", v); end
    rd(2'd0, v); n_cmp++;
    if (v !== 32'd100) begin n_err++; $display("FAIL partial_width_kept got %0d want 100", v); end
    pulse(50);
    cyc(LAT + 3);
    rd(2'd0, v); n_cmp++;
    if (v !== 32'd50) begin n_err++; $display("FAIL partial_width got %0d want 50", v); end
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h1) begin n_err++; $display("FAIL partial_status got %0h want 1", v); end
    wr(2'd1, 32'h1);
  endtask

  task automatic test_timeout;
    logic [31:0] v;
    wr(2'd3, 32'd20);
    rd(2'd3, v); n_cmp++;
    if (v !== 32'd20) begin n_err++; $display("FAIL tmo_reg got %0d want 20", v); end
    @(posedge clk); #1; echo_in = 1'b1;
    cyc(30);
    rd(2'd1, v); n_cmp++;
    if (v !== 32'hA) begin n_err++; $display("FAIL tmo_status got %0h want a", v); end
    rd(2'd0, v); n_cmp++;
    if (v !== 32'd20) begin n_err++; $display("FAIL tmo_width got %0d want 20", v); end
    cyc(10);
    echo_in = 1'b0;
    cyc(LAT + 3);
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h2) begin n_err++; $display("FAIL tmo_after status got %0h want 2", v); end
    pulse(10);
    cyc(LAT + 3);
    rd(2'd0, v); n_cmp++;
    if (v !== 32'd10) begin n_err++; $display("FAIL tmo_next_width got %0d want 10", v); end
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h3) begin n_err++; $display("FAIL tmo_next_status got %0h want 3", v); end
    wr(2'd1, 32'h3);
    wr(2'd3, 32'd0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    pulse(10);
    cyc(LAT + 3);
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h1) begin n_err++; $display("FAIL b2b_first status got %0h want 1", v); end
    pulse(15);
    repeat (LAT - 1) @(posedge clk);
    wr(2'd1, 32'h1);
    cyc(1);
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h1) begin n_err++; $display("FAIL b2b_set_wins status got %0h want 1", v); end
    rd(2'd0, v); n_cmp++;
    if (v !== 32'd15) begin n_err++; $display("FAIL b2b_width got %0d want 15", v); end
    wr(2'd1, 32'h1);
  endtask

  task automatic test_en_clear;
    logic [31:0] v;
    @(posedge clk); #1; echo_in = 1'b1;
    cyc(10);
    wr(2'd2, 32'h0);
    cyc(5);
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h8) begin n_err++; $display("FAIL en_clear_idle status got %0h want 8", v); end
    cyc(15);
    echo_in = 1'b0;
    cyc(LAT + 3);
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL en_clear_no_done status got %0h want 0", v); end
    rd(2'd0, v); n_cmp++;
    if (v !== 32'd15) begin n_err++; $display("FAIL en_clear_width got %0d want 15", v); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    wr(2'd2, 32'h3);
    cyc(3);
    echo_in = 1'b1;
    cyc(LAT + 10);
    rd(2'd1, v); n_cmp++;
    if (v !== 32'hC) begin n_err++; $display("FAIL rst_mid_busy status got %0h want c", v); end
    reset = 1'b1;
    #1;
    rd(2'd0, v); n_cmp++;
    if (v !== 32'd0) begin n_err++; $display("FAIL rst_mid_width got %0d want 0", v); end
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL rst_mid_status got %0h want 0", v); end
    rd(2'd2, v); n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL rst_mid_control got %0h want 0", v); end
    rd(2'd3, v); n_cmp++;
    if (v !== 32'd1900000) begin n_err++; $display("FAIL rst_mid_timeout got %0d want 1900000", v); end
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL rst_mid_irq got %b want 0", irq); end
    cyc(2);
    reset = 1'b0;
    wr(2'd2, 32'h1);
    cyc(LAT + 6);
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h8) begin n_err++; $display("FAIL rearm_wait_low status got %0h want 8", v); end
    echo_in = 1'b0;
    cyc(LAT + 3);
    pulse(12);
    cyc(LAT + 3);
    rd(2'd0, v); n_cmp++;
    if (v !== 32'd12) begin n_err++; $display("FAIL rearm_width got %0d want 12", v); end
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h1) begin n_err++; $display("FAIL rearm_status got %0h want 1", v); end
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL rearm_irq_masked got %b want 0", irq); end
    wr(2'd1, 32'h1);
  endtask

`ifdef HCECHO_GLITCH_FILTER_EN
  task automatic test_glitch;
    logic [31:0] v;
    pulse(2);
    cyc(12);
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL glitch_status got %0h want 0", v); end
    rd(2'd0, v); n_cmp++;
    if (v !== 32'd12) begin n_err++; $display("FAIL glitch_width got %0d want 12", v); end
    pulse(20);
    cyc(LAT + 3);
    rd(2'd0, v); n_cmp++;
    if (v !== 32'd20) begin n_err++; $display("FAIL filt_width got %0d want 20", v); end
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h1) begin n_err++; $display("FAIL filt_status got %0h want 1", v); end
  endtask
`else
  task automatic test_min_pulse;
    logic [31:0] v;
    pulse(1);
    cyc(LAT + 3);
    rd(2'd0, v); n_cmp++;
    if (v !== 32'd1) begin n_err++; $display("FAIL min_pulse_width got %0d want 1", v); end
    rd(2'd1, v); n_cmp++;
    if (v !== 32'h1) begin n_err++; $display("FAIL min_pulse_status got %0h want 1", v); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_partial;
    test_timeout;
    test_back_to_back;
    test_en_clear;
    test_reset_mid;
`ifdef HCECHO_GLITCH_FILTER_EN
    test_glitch;
`else
    test_min_pulse;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
